hilo_mul_seq: RTL

- Multi-cycle sequencer for MULT/MULTU. Owns the HI/LO architectural registers.
- Runs an iterative shift-add multiply on magnitudes; signed products are fixed up by a final negate.
- Sits in EX beside the ALU. Issues stall_req to the pipeline controller while a product is pending.
- Also services MTHI/MTLO writes and supplies HI/LO for MFHI/MFLO.

---
 rtl/hilo_mul_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/hilo_mul_seq.sv
// hilo_mul_seq: multi-cycle MULT/MULTU sequencer that owns the HI/LO registers.
//
// It runs an iterative shift-add multiply on operand magnitudes. Signed products
// are corrected by a single negate at completion. It also services MTHI/MTLO
// writes and presents HI/LO for MFHI/MFLO.
//
// Optional build macro: HILO_MUL_EARLY_TERM_EN
//   When defined, the multiply ends as soon as the remaining multiplier bits are
//   all zero. When undefined, a multiply always takes N = 32/BITS_PER_CYCLE
//   cycles.
//
// Parameters:
//   BITS_PER_CYCLE  multiplier bits retired per RUN cycle (1, 2, 4 or 8)
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      issue MULT/MULTU (sampled only in IDLE)
//   is_signed_i  1 = MULT, 0 = MULTU (sampled with start_i)
//   a_i, b_i     rs / rt operands (sampled with start_i)
//   cancel_i     pipeline flush; aborts the operation in flight
//   hi_we_i      MTHI write enable
//   lo_we_i      MTLO write enable
//   wdata_i      MTHI/MTLO write data
//   rd_hilo_i    MFHI/MFLO present in EX
//   busy_o       multiply in progress (RUN state)
//   done_o       one-cycle pulse when HI/LO take a new product
//   stall_req_o  combinational: busy & (rd_hilo | hi_we | lo_we | start)
//   hi_o, lo_o   HI/LO architectural registers
module hilo_mul_seq #(
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic        is_signed_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        cancel_i,
   input  logic        hi_we_i,
   input  logic        lo_we_i,
   input  logic [31:0] wdata_i,
   input  logic        rd_hilo_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        stall_req_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam int unsigned N        = 32 / BITS_PER_CYCLE;
   localparam int unsigned CNT_W    = 6;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [63:0]      mc_q, mc_d;     // multiplicand, pre-shifted to the current digit weight
   logic [31:0]      mp_q, mp_d;     // remaining multiplier bits, LSB digit first
   logic [63:0]      acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic             done_q, done_d;

   logic [31:0]               abs_a, abs_b;
   logic [BITS_PER_CYCLE-1:0] digit;
   logic [63:0]               pp;
   logic [63:0]               acc_sum;
   logic [63:0]               result;
   logic [31:0]               mp_shift;
   logic                      last_iter;

   // Operand magnitudes; |0x80000000| stays 0x80000000 as an unsigned value.
   assign abs_a = (is_signed_i && a_i[31]) ? (32'd0 - a_i) : a_i;
   assign abs_b = (is_signed_i && b_i[31]) ? (32'd0 - b_i) : b_i;

   // One digit's partial product, already aligned because mc_q shifts every cycle.
   assign digit    = mp_q[BITS_PER_CYCLE-1:0];
   assign pp       = mc_q * 64'(digit);
   assign acc_sum  = acc_q + pp;
   assign result   = neg_q ? (64'd0 - acc_sum) : acc_sum;
   assign mp_shift = mp_q >> BITS_PER_CYCLE;

`ifdef HILO_MUL_EARLY_TERM_EN
   // Stop once no multiplier bits remain; remaining digits would add zero.
   assign last_iter = (cnt_q == LAST_CNT) || (mp_shift == 32'd0);
`else
   assign last_iter = (cnt_q == LAST_CNT);
`endif

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      mc_d    = mc_q;
      mp_d    = mp_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            // MTHI/MTLO land even alongside a start; completion overwrites them.
            if (hi_we_i) hi_d = wdata_i;
            if (lo_we_i) lo_d = wdata_i;
            if (start_i && !cancel_i) begin
               state_d = S_RUN;
               mc_d    = {32'd0, abs_a};
               mp_d    = abs_b;
               neg_d   = is_signed_i & (a_i[31] ^ b_i[31]);
               acc_d   = 64'd0;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            if (cancel_i) begin
               state_d = S_IDLE;
            end else begin
               acc_d = acc_sum;
               mc_d  = mc_q << BITS_PER_CYCLE;
               mp_d  = mp_shift;
               cnt_d = cnt_q + CNT_W'(1);
               if (last_iter) begin
                  state_d      = S_IDLE;
                  {hi_d, lo_d} = result;
                  done_d       = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         mc_q    <= 64'd0;
         mp_q    <= 32'd0;
         acc_q   <= 64'd0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mc_q    <= mc_d;
         mp_q    <= mp_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy_o      = (state_q == S_RUN);
   assign done_o      = done_q;
   assign hi_o        = hi_q;
   assign lo_o        = lo_q;
   // Holds any HI/LO consumer or producer in EX until the product lands.
   assign stall_req_o = busy_o & (rd_hilo_i | hi_we_i | lo_we_i | start_i);

endmodule
